// File: rtl/ptp_timebase_if.sv
// ptp_timebase_if
//   Groups the timebase outputs and the level-delay trigger into one bundle.
//   slave  : the timebase itself (drives ticks and delay status, reads dly_in)
//   master : the consumer (punch controller or testbench)
//   Signals:
//     tick_50khz  one-cycle 50 kHz simulation tick
//     tick_63hz   one-cycle 63.3 Hz punch-sync tick
//     dly_in      trigger/hold input for the 10 ms level delay
//     dly_level   delay-active level
//     dly_end     one-cycle pulse when the delay expires
interface ptp_timebase_if;
  logic tick_50khz;
  logic tick_63hz;
  logic dly_in;
  logic dly_level;
  logic dly_end;

  modport slave (
    output tick_50khz,
    output tick_63hz,
    input  dly_in,
    output dly_level,
    output dly_end
  );

  modport master (
    input  tick_50khz,
    input  tick_63hz,
    output dly_in,
    input  dly_level,
    input  dly_end
  );
endinterface

// File: rtl/ptp_timebase.sv
// ptp_timebase
//   Timebase for the KA10 paper-tape punch: two free-running tick generators
//   plus one retriggerable level delay that gates punch data and marks the
//   end of each punch cycle. Every output is a flop; no input reaches an
//   output combinationally.
//   Ports:
//     clk    system clock, rising edge (50 MHz nominal)
//     reset  asynchronous, active-low reset
//     bus    ptp_timebase_if slave: ticks, dly_in, dly_level, dly_end
module ptp_timebase #(
  parameter int DIV_50K    = 1000,
  parameter int DIV_63HZ   = 789889,
  parameter int DLY_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           reset,
  ptp_timebase_if.slave  bus
);

  // Widths are clamped to 1 so a divide-by-1 still elaborates.
  localparam int W50 = (DIV_50K  > 1) ? $clog2(DIV_50K)  : 1;
  localparam int W63 = (DIV_63HZ > 1) ? $clog2(DIV_63HZ) : 1;
  localparam int WD  = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES + 1) : 1;

  localparam logic [W50-1:0] LAST_50K  = W50'(DIV_50K - 1);
  localparam logic [W63-1:0] LAST_63HZ = W63'(DIV_63HZ - 1);
  localparam logic [WD-1:0]  DLY_LOAD  = WD'(DLY_CYCLES);
  localparam logic [WD-1:0]  DLY_ONE   = WD'(1);

  logic [W50-1:0] cnt_50k;
  logic [W63-1:0] cnt_63hz;
  logic [WD-1:0]  dly_cnt;
  logic           tick_50khz_q;
  logic           tick_63hz_q;
  logic           dly_level_q;
  logic           dly_end_q;

  // 50 kHz tick: the tick flop goes high on the same edge the counter wraps,
  // so it is visible for the one cycle after the DIV-th edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_50k      <= '0;
      tick_50khz_q <= 1'b0;
    end else if (cnt_50k == LAST_50K) begin
      cnt_50k      <= '0;
      tick_50khz_q <= 1'b1;
    end else begin
      cnt_50k      <= cnt_50k + 1'b1;
      tick_50khz_q <= 1'b0;
    end
  end

  // 63.3 Hz punch-sync tick, same structure as the fast tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_63hz    <= '0;
      tick_63hz_q <= 1'b0;
    end else if (cnt_63hz == LAST_63HZ) begin
      cnt_63hz    <= '0;
      tick_63hz_q <= 1'b1;
    end else begin
      cnt_63hz    <= cnt_63hz + 1'b1;
      tick_63hz_q <= 1'b0;
    end
  end

  // Level delay. A trigger always reloads the count, so a trigger on the
  // expiry edge wins and suppresses dly_end. dly_end is cleared on every
  // edge except the expiry edge, keeping it a single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dly_cnt     <= '0;
      dly_level_q <= 1'b0;
      dly_end_q   <= 1'b0;
    end else if (bus.dly_in) begin
      dly_cnt     <= DLY_LOAD;
      dly_level_q <= 1'b1;
      dly_end_q   <= 1'b0;
    end else if (dly_level_q && (dly_cnt > DLY_ONE)) begin
      dly_cnt     <= dly_cnt - 1'b1;
      dly_end_q   <= 1'b0;
    end else if (dly_level_q) begin
      dly_level_q <= 1'b0;
      dly_end_q   <= 1'b1;
    end else begin
      dly_end_q   <= 1'b0;
    end
  end

  assign bus.tick_50khz = tick_50khz_q;
  assign bus.tick_63hz  = tick_63hz_q;
  assign bus.dly_level  = dly_level_q;
  assign bus.dly_end    = dly_end_q;

endmodule

// File: tb/tb_ptp_timebase.sv
// tb_ptp_timebase
//   Directed testbench for ptp_timebase. One small instance (DIV_50K=4,
//   DIV_63HZ=7, DLY_CYCLES=5) exercises ticks and the level delay; a second
//   instance with default parameters has its 50 kHz tick period measured.
module tb_ptp_timebase;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  ptp_timebase_if bus_a ();
  ptp_timebase_if bus_d ();

  assign bus_d.dly_in = 1'b0;

  ptp_timebase #(
    .DIV_50K    (4),
    .DIV_63HZ   (7),
    .DLY_CYCLES (5)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  ptp_timebase dut_d (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_d)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge counter used for period measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held low with dly_in high: every output must stay 0.
  task automatic test_reset();
    reset        = 1'b1;
    bus_a.dly_in = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({bus_a.tick_50khz, bus_a.tick_63hz, bus_a.dly_level, bus_a.dly_end} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d got %b expected 0000", k,
                 {bus_a.tick_50khz, bus_a.tick_63hz, bus_a.dly_level, bus_a.dly_end});
      end
      checks++;
      if ({bus_d.tick_50khz, bus_d.tick_63hz, bus_d.dly_level, bus_d.dly_end} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_outputs_default cycle %0d got %b expected 0000", k,
                 {bus_d.tick_50khz, bus_d.tick_63hz, bus_d.dly_level, bus_d.dly_end});
      end
    end
    bus_a.dly_in = 1'b0;
  endtask

  // Release reset; ticks expected after edges 4,8,12 and 7,14.
  task automatic test_ticks();
    logic e50;
    logic e63;
    reset = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      step();
      e50 = (n == 4) || (n == 8) || (n == 12);
      e63 = (n == 7) || (n == 14);
      checks++;
      if (bus_a.tick_50khz !== e50) begin
        errors++;
        $display("[TB] FAIL tick_50khz edge %0d got %b expected %b", n, bus_a.tick_50khz, e50);
      end
      checks++;
      if (bus_a.tick_63hz !== e63) begin
        errors++;
        $display("[TB] FAIL tick_63hz edge %0d got %b expected %b", n, bus_a.tick_63hz, e63);
      end
    end
  endtask

  // One-cycle trigger: level high after E..E+4, falls with dly_end at E+5.
  task automatic test_single_trigger();
    logic el;
    logic ee;
    bus_a.dly_in = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      bus_a.dly_in = 1'b0;
      el = (k <= 4);
      ee = (k == 5);
      checks++;
      if (bus_a.dly_level !== el) begin
        errors++;
        $display("[TB] FAIL single_level k=%0d got %b expected %b", k, bus_a.dly_level, el);
      end
      checks++;
      if (bus_a.dly_end !== ee) begin
        errors++;
        $display("[TB] FAIL single_end k=%0d got %b expected %b", k, bus_a.dly_end, ee);
      end
    end
    repeat (3) step();
  endtask

  // Triggers at E and E+3: level stays high through E+7, falls at E+8.
  task automatic test_retrigger();
    logic el;
    logic ee;
    bus_a.dly_in = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      bus_a.dly_in = (k == 2);
      el = (k <= 7);
      ee = (k == 8);
      checks++;
      if (bus_a.dly_level !== el) begin
        errors++;
        $display("[TB] FAIL retrig_level k=%0d got %b expected %b", k, bus_a.dly_level, el);
      end
      checks++;
      if (bus_a.dly_end !== ee) begin
        errors++;
        $display("[TB] FAIL retrig_end k=%0d got %b expected %b", k, bus_a.dly_end, ee);
      end
    end
    repeat (3) step();
  endtask

  // A trigger on the expiry edge E+5 reloads; the delay then ends at E+10.
  task automatic test_trigger_on_expiry();
    logic el;
    logic ee;
    bus_a.dly_in = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      bus_a.dly_in = (k == 4);
      el = (k <= 9);
      ee = (k == 10);
      checks++;
      if (bus_a.dly_level !== el) begin
        errors++;
        $display("[TB] FAIL expiry_level k=%0d got %b expected %b", k, bus_a.dly_level, el);
      end
      checks++;
      if (bus_a.dly_end !== ee) begin
        errors++;
        $display("[TB] FAIL expiry_end k=%0d got %b expected %b", k, bus_a.dly_end, ee);
      end
    end
    repeat (3) step();
  endtask

  // dly_in held for 20 edges, then 4 more high cycles and one dly_end.
  task automatic test_held();
    logic el;
    logic ee;
    bus_a.dly_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 19) bus_a.dly_in = 1'b0;
      checks++;
      if ({bus_a.dly_level, bus_a.dly_end} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL held_active k=%0d got %b expected 10", k,
                 {bus_a.dly_level, bus_a.dly_end});
      end
    end
    for (int j = 1; j <= 6; j++) begin
      step();
      el = (j <= 4);
      ee = (j == 5);
      checks++;
      if ({bus_a.dly_level, bus_a.dly_end} !== {el, ee}) begin
        errors++;
        $display("[TB] FAIL held_release j=%0d got %b expected %b", j,
                 {bus_a.dly_level, bus_a.dly_end}, {el, ee});
      end
    end
    repeat (3) step();
  endtask

  // Reset two cycles into a delay: level drops at once, no dly_end later,
  // and the tick counters restart from zero.
  task automatic test_reset_mid_delay();
    logic e50;
    bus_a.dly_in = 1'b1;
    step();
    bus_a.dly_in = 1'b0;
    step();
    step();
    checks++;
    if (bus_a.dly_level !== 1'b1) begin
      errors++;
      $display("[TB] FAIL middelay_pre_level got %b expected 1", bus_a.dly_level);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_a.dly_level, bus_a.dly_end} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL middelay_async_clear got %b expected 00",
               {bus_a.dly_level, bus_a.dly_end});
    end
    step();
    step();
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      e50 = (k == 4) || (k == 8);
      checks++;
      if ({bus_a.dly_level, bus_a.dly_end, bus_a.tick_50khz} !== {2'b00, e50}) begin
        errors++;
        $display("[TB] FAIL middelay_after k=%0d got %b expected %b", k,
                 {bus_a.dly_level, bus_a.dly_end, bus_a.tick_50khz}, {2'b00, e50});
      end
    end
  endtask

  // Default instance: successive tick_50khz rising edges 1000 cycles apart,
  // each tick one cycle wide.
  task automatic test_defaults();
    int first;
    int second;
    int width;
    bit prev;
    first  = -1;
    second = -1;
    width  = 0;
    prev   = 1'b0;
    for (int k = 0; k < 2600 && second < 0; k++) begin
      step();
      if (bus_d.tick_50khz === 1'b1) width++;
      if (bus_d.tick_50khz === 1'b1 && !prev) begin
        if (first < 0) first = cyc;
        else           second = cyc;
      end
      prev = (bus_d.tick_50khz === 1'b1);
    end
    step();
    if (bus_d.tick_50khz === 1'b1) width++;
    checks++;
    if (second < 0) begin
      errors++;
      $display("[TB] FAIL default_tick_timeout got first=%0d second=%0d expected two ticks",
               first, second);
    end else if (second - first !== 1000) begin
      errors++;
      $display("[TB] FAIL default_tick_period got %0d expected 1000", second - first);
    end
    checks++;
    if (width !== 2) begin
      errors++;
      $display("[TB] FAIL default_tick_width got %0d high cycles for 2 ticks expected 2", width);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    reset        = 1'b1;
    bus_a.dly_in = 1'b0;
    test_reset();
    test_ticks();
    test_single_trigger();
    test_retrigger();
    test_trigger_on_expiry();
    test_held();
    test_reset_mid_delay();
    test_defaults();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
